// File: rtl/keypad_digit_loader_pkg.sv
`default_nettype none
// keypad_digit_loader_pkg: shared widths and FSM state encoding for the keypad loader. (rev 1.0)
package keypad_digit_loader_pkg;

  localparam int DIGIT_W  = 4;
  localparam int NUM_KEYS = 10;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_LOAD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/keypad_onehot_to_bcd.sv
`default_nettype none
// keypad_onehot_to_bcd: one-hot key vector to BCD digit; valid only when exactly one bit is set. (rev 1.0)
module keypad_onehot_to_bcd
  import keypad_digit_loader_pkg::*;
(
  input  logic [NUM_KEYS-1:0] onehot,
  output logic [DIGIT_W-1:0]  bcd,
  output logic                valid
);

  logic [3:0] ones;

  always_comb begin
    bcd  = '0;
    ones = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (onehot[i]) begin
        bcd  = DIGIT_W'(i);
        ones = ones + 4'd1;
      end
    end
    valid = (ones == 4'd1);
  end

endmodule
`default_nettype wire

// File: rtl/keypad_digit_loader.sv
`default_nettype none
// keypad_digit_loader: debounces a decimal keypad and emits a BCD digit with a one-clock active-low load strobe. (rev 1.0)
module keypad_digit_loader
  import keypad_digit_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                clrn,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                busy,
  input  logic                clear,
  output logic [DIGIT_W-1:0]  data,
  output logic                loadn,
  output logic [1:0]          digit_count,
  output logic                key_active
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_KEYS-1:0] pattern;
  logic [DIGIT_W-1:0]  key_bcd;
  logic                key_valid;

  keypad_onehot_to_bcd u_decode (
    .onehot (keys),
    .bcd    (key_bcd),
    .valid  (key_valid)
  );

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pattern     <= '0;
      data        <= '0;
      loadn       <= 1'b1;
      digit_count <= 2'd0;
      key_active  <= 1'b0;
    end else begin
      loadn <= 1'b1;

      // clear takes priority over the increment made on the edge leaving LOAD
      if (clear)
        digit_count <= 2'd0;
      else if (state == ST_LOAD && digit_count != 2'd3)
        digit_count <= digit_count + 2'd1;

      case (state)
        ST_IDLE: begin
          if (!busy && key_valid) begin
            pattern <= keys;
            cnt     <= CNT_W'(1);
            state   <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (busy || keys != pattern) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            data       <= key_bcd;
            loadn      <= 1'b0;
            key_active <= 1'b1;
            state      <= ST_LOAD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_LOAD: begin
          cnt   <= '0;
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // any key activity, valid or not, restarts the release qualification
          if (keys != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt        <= '0;
            key_active <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_digit_loader.sv
`default_nettype none
// tb_keypad_digit_loader: directed and random stimulus against a run-length model of the keypad loader.
module tb_keypad_digit_loader;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       clrn;
  logic [9:0] keys;
  logic       busy;
  logic       clear;
  logic [3:0] data;
  logic       loadn;
  logic [1:0] digit_count;
  logic       key_active;

  int checks = 0;
  int errors = 0;
  int nstrobe = 0;
  bit chk_en = 1'b0;

  keypad_digit_loader #(.DEBOUNCE_CYCLES(N)) dut (
    .clock       (clock),
    .clrn        (clrn),
    .keys        (keys),
    .busy        (busy),
    .clear       (clear),
    .data        (data),
    .loadn       (loadn),
    .digit_count (digit_count),
    .key_active  (key_active)
  );

  always #5 clock = ~clock;

  // Model: press_run counts identical valid samples, zero_run counts idle samples after a strobe.
  int         m_press_run = 0;
  int         m_zero_run  = 0;
  bit         m_strobe    = 1'b0;
  bit         m_releasing = 1'b0;
  logic [9:0] m_pat       = '0;
  int         m_data      = 0;
  int         m_count     = 0;

  function automatic int key_index(input logic [9:0] k);
    int idx = 0;
    for (int i = 0; i < 10; i++) if (k[i]) idx = i;
    return idx;
  endfunction

  always @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      m_press_run = 0; m_zero_run = 0; m_strobe = 1'b0; m_releasing = 1'b0;
      m_pat = '0; m_data = 0; m_count = 0;
    end else if (m_strobe) begin
      m_strobe    = 1'b0;
      m_releasing = 1'b1;
      m_zero_run  = 0;
      m_count     = clear ? 0 : (m_count >= 3 ? 3 : m_count + 1);
    end else begin
      if (clear) m_count = 0;
      if (m_releasing) begin
        m_zero_run = (keys == '0) ? m_zero_run + 1 : 0;
        if (m_zero_run == N) m_releasing = 1'b0;
      end else if (m_press_run > 0) begin
        if (busy || keys != m_pat) begin
          m_press_run = 0;
        end else begin
          m_press_run++;
          if (m_press_run == N) begin
            m_strobe    = 1'b1;
            m_data      = key_index(keys);
            m_press_run = 0;
          end
        end
      end else if (!busy && $countones(keys) == 1) begin
        m_pat       = keys;
        m_press_run = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("loadn",       32'(loadn),       32'(!m_strobe));
      chk("data",        32'(data),        32'(m_data));
      chk("digit_count", 32'(digit_count), 32'(m_count));
      chk("key_active",  32'(key_active),  32'(m_strobe || m_releasing));
    end
    if (clrn === 1'b1 && loadn === 1'b0) nstrobe++;
  end

  task automatic apply(input logic [9:0] k, input logic b, input logic c, input int n);
    keys = k; busy = b; clear = c;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int s0;
    logic [9:0] k;
    clrn = 1'b0; keys = '0; busy = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_loadn", 32'(loadn), 32'd1);
    chk("rst_data",  32'(data), 32'd0);
    chk("rst_count", 32'(digit_count), 32'd0);
    chk("rst_active", 32'(key_active), 32'd0);
    clrn = 1'b1;
    chk_en = 1'b1;

    apply('0, 0, 0, 20);
    chk("idle_loadn", 32'(loadn), 32'd1);
    chk("idle_strobes", 32'(nstrobe), 32'd0);

    // key 2: strobe exactly after the 4th sampling edge
    s0 = nstrobe;
    keys = 10'b0000000100;
    repeat (3) @(posedge clock);
    #1 chk("pre_strobe_loadn", 32'(loadn), 32'd1);
    @(posedge clock);
    #1 chk("strobe_loadn", 32'(loadn), 32'd0);
    @(posedge clock);
    #1 chk("post_strobe_loadn", 32'(loadn), 32'd1);
    @(negedge clock);
    apply(10'b0000000100, 0, 0, 5);
    apply('0, 0, 0, 8);
    chk("k2_strobes", 32'(nstrobe - s0), 32'd1);
    chk("k2_data", 32'(data), 32'd2);
    chk("k2_count", 32'(digit_count), 32'd1);

    s0 = nstrobe;
    apply(10'b1000000000, 0, 0, 3);
    apply('0, 0, 0, 8);
    chk("glitch_strobes", 32'(nstrobe - s0), 32'd0);
    chk("glitch_data", 32'(data), 32'd2);

    s0 = nstrobe;
    apply(10'b0000100010, 0, 0, 10);
    chk("multi_strobes", 32'(nstrobe - s0), 32'd0);
    apply(10'b0000100000, 0, 0, 10);
    apply('0, 0, 0, 8);
    chk("k5_strobes", 32'(nstrobe - s0), 32'd1);
    chk("k5_data", 32'(data), 32'd5);

    s0 = nstrobe;
    foreach (k[i]) k[i] = 1'b0;
    for (int p = 0; p < 4; p++) begin
      int d;
      d = (p == 0) ? 2 : (p == 3) ? 7 : 0;
      k = '0; k[d] = 1'b1;
      apply(k, 0, 0, 6);
      apply('0, 0, 0, 6);
    end
    chk("seq_strobes", 32'(nstrobe - s0), 32'd4);
    chk("seq_data", 32'(data), 32'd7);
    chk("seq_count_sat", 32'(digit_count), 32'd3);
    apply('0, 0, 1, 1);
    chk("clear_count", 32'(digit_count), 32'd0);

    s0 = nstrobe;
    apply(10'b0000001000, 0, 0, 2);
    apply(10'b0000001000, 1, 0, 6);
    apply('0, 0, 0, 6);
    chk("busy_abort_strobes", 32'(nstrobe - s0), 32'd0);
    chk("busy_abort_data", 32'(data), 32'd7);

    // asynchronous reset landing inside the LOAD cycle
    keys = 10'b0001000000;
    repeat (4) @(posedge clock);
    #1 chk("load_before_rst", 32'(loadn), 32'd0);
    #1 clrn = 1'b0;
    #1 chk("rst_mid_loadn", 32'(loadn), 32'd1);
    chk("rst_mid_data", 32'(data), 32'd0);
    chk("rst_mid_count", 32'(digit_count), 32'd0);
    chk("rst_mid_active", 32'(key_active), 32'd0);
    @(negedge clock);
    keys = '0;
    @(negedge clock);
    clrn = 1'b1;

    for (int seg = 0; seg < 400; seg++) begin
      int r, d1, d2, len;
      logic c;
      r   = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      c   = ($urandom_range(0, 15) == 0);
      d1  = $urandom_range(0, 9);
      d2  = $urandom_range(0, 9);
      k   = '0;
      if (r >= 4 && r <= 8) k[d1] = 1'b1;
      if (r == 7) k[d2] = 1'b1;
      if (c) begin
        apply(k, r == 8, 1'b1, 1);
        if (len > 1) apply(k, r == 8, 1'b0, len - 1);
      end else begin
        apply(k, r == 8, r == 9, len);
      end
    end
    apply('0, 0, 0, 10);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
